// File: rtl/reset_requester_pkg.sv
// reset_requester_pkg
//   Shared types for the reset requester: FSM state encoding and the
//   request-cause codes reported on io_cause.
package reset_requester_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_REQUEST = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'b00,
      CAUSE_BUTTON = 2'b01,
      CAUSE_WDT    = 2'b10
   } cause_e;

   // io_reset_req pulse length counter; covers HOLD_CYCLES up to 255
   localparam int HOLD_CNT_BITS = 8;

endpackage

// File: rtl/reset_requester_if.sv
// reset_requester_if
//   Groups the core-facing signals of the reset requester.
//   master : core / board side, drives button, terminate, kick, wdt enable
//   slave  : reset_requester, drives reset request, halted flag and cause
interface reset_requester_if;
   import reset_requester_pkg::*;

   logic       io_button_n;
   logic       io_terminate;
   logic       io_kick;
   logic       io_wdt_enable;
   logic       io_reset_req;
   logic       io_halted;
   logic [1:0] io_cause;

   modport master (
      output io_button_n,
      output io_terminate,
      output io_kick,
      output io_wdt_enable,
      input  io_reset_req,
      input  io_halted,
      input  io_cause
   );

   modport slave (
      input  io_button_n,
      input  io_terminate,
      input  io_kick,
      input  io_wdt_enable,
      output io_reset_req,
      output io_halted,
      output io_cause
   );

endinterface

// File: rtl/button_debounce.sv
// button_debounce
//   Two-flop synchronizer followed by a debouncer for an active-low push
//   button. The debounced level only flips after the synchronized input has
//   differed from it for 2^DEBOUNCE_BITS consecutive cycles; any return to
//   the current debounced level clears the counter. A one-cycle press pulse
//   is emitted when the debounced level falls, so a held button yields one
//   event and a new event needs a debounced release first.
//   Ports:
//     clock     in   system clock
//     reset     in   synchronous active-high reset
//     button_n  in   raw asynchronous button, active-low
//     press     out  registered single-cycle press event
module button_debounce
   import reset_requester_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic button_n,
   output logic press
);

   localparam logic [DEBOUNCE_BITS-1:0] CNT_TC  = '1;
   localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = 1;

   logic                     sync1_q, sync1_d;
   logic                     sync2_q, sync2_d;
   logic                     level_q, level_d;
   logic [DEBOUNCE_BITS-1:0] cnt_q,   cnt_d;
   logic                     press_q, press_d;

   always_comb begin
      sync1_d = button_n;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         // cnt_q == CNT_TC marks the 2^DEBOUNCE_BITS-th differing cycle
         if (cnt_q == CNT_TC) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/reset_requester.sv
// reset_requester
//   Raises a fixed-length reset request towards the reset stretcher on a
//   debounced button press or a watchdog timeout, and parks the core in a
//   halted state after it signals termination. Its own reset must come from
//   the PLL-lock-qualified top-level reset, never from io_reset_req.
//   Ports:
//     clock   in   system clock
//     reset   in   synchronous active-high reset
//     bus     slave modport of reset_requester_if
//               io_button_n, io_terminate, io_kick, io_wdt_enable  (in)
//               io_reset_req, io_halted, io_cause                  (out)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | core running; watchdog counts down while enabled
//   ST_HALTED  | core terminated and parked; only a button press leaves
//   ST_REQUEST | io_reset_req high for HOLD_CYCLES cycles, events ignored
module reset_requester
   import reset_requester_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 16,
   parameter int WDT_BITS      = 24,
   parameter int HOLD_CYCLES   = 16
) (
   input  logic              clock,
   input  logic              reset,
   reset_requester_if.slave  bus
);

   localparam logic [WDT_BITS-1:0]      WDT_RELOAD = '1;
   localparam logic [WDT_BITS-1:0]      WDT_ONE    = 1;
   localparam logic [HOLD_CNT_BITS-1:0] HOLD_LOAD  = HOLD_CNT_BITS'(HOLD_CYCLES - 1);
   localparam logic [HOLD_CNT_BITS-1:0] HOLD_ONE   = 1;

   state_e                   state_q,     state_d;
   logic [WDT_BITS-1:0]      wdt_q,       wdt_d;
   logic [HOLD_CNT_BITS-1:0] hold_q,      hold_d;
   logic                     reset_req_q, reset_req_d;
   logic                     halted_q,    halted_d;
   cause_e                   cause_q,     cause_d;

   logic press_evt;
   logic wdt_expire;

   button_debounce #(
      .DEBOUNCE_BITS (DEBOUNCE_BITS)
   ) u_debounce (
      .clock    (clock),
      .reset    (reset),
      .button_n (bus.io_button_n),
      .press    (press_evt)
   );

   // Expiry looks only at the count, so a kick in the same cycle cannot
   // rescue it.
   assign wdt_expire = bus.io_wdt_enable && (wdt_q == '0);

   always_comb begin
      state_d = state_q;
      wdt_d   = WDT_RELOAD;
      hold_d  = hold_q;
      cause_d = cause_q;

      unique case (state_q)
         ST_RUN: begin
            if (press_evt) begin
               state_d = ST_REQUEST;
               hold_d  = HOLD_LOAD;
               cause_d = CAUSE_BUTTON;
            end else if (wdt_expire) begin
               state_d = ST_REQUEST;
               hold_d  = HOLD_LOAD;
               cause_d = CAUSE_WDT;
            end else if (bus.io_terminate) begin
               state_d = ST_HALTED;
            end else if (bus.io_wdt_enable && !bus.io_kick) begin
               wdt_d = wdt_q - WDT_ONE;
            end
         end

         ST_HALTED: begin
            if (press_evt) begin
               state_d = ST_REQUEST;
               hold_d  = HOLD_LOAD;
               cause_d = CAUSE_BUTTON;
            end
         end

         ST_REQUEST: begin
            // hold_q counts remaining pulse cycles after the current one
            if (hold_q == '0) begin
               state_d = ST_RUN;
            end else begin
               hold_d = hold_q - HOLD_ONE;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Outputs follow the next state so they are plain flops
      reset_req_d = (state_d == ST_REQUEST);
      halted_d    = (state_d == ST_HALTED);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         wdt_q       <= WDT_RELOAD;
         hold_q      <= '0;
         reset_req_q <= 1'b0;
         halted_q    <= 1'b0;
         cause_q     <= CAUSE_NONE;
      end else begin
         state_q     <= state_d;
         wdt_q       <= wdt_d;
         hold_q      <= hold_d;
         reset_req_q <= reset_req_d;
         halted_q    <= halted_d;
         cause_q     <= cause_d;
      end
   end

   assign bus.io_reset_req = reset_req_q;
   assign bus.io_halted    = halted_q;
   assign bus.io_cause     = cause_q;

endmodule

// File: tb/tb_reset_requester.sv
// tb_reset_requester
//   Bench for reset_requester with DEBOUNCE_BITS=4, WDT_BITS=6, HOLD_CYCLES=4.
//   Expected pulses are queued when stimulus is driven; a monitor measures
//   every io_reset_req pulse and compares it against the queue head.
module tb_reset_requester;
   import reset_requester_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;

   reset_requester_if bus ();

   reset_requester #(
      .DEBOUNCE_BITS (4),
      .WDT_BITS      (6),
      .HOLD_CYCLES   (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clock) cyc++;

   typedef struct {
      int cause;
      int len;
      int at;     // expected rise cycle, -1 = not checked
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   pulse_count = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // pulse monitor / scoreboard consumer
   logic prev_req = 1'b0;
   int   cur_len  = 0;
   int   rise_at  = 0;
   int   rise_cause = 0;

   always @(negedge clock) begin
      if (bus.io_reset_req === 1'b1) begin
         if (!prev_req) begin
            rise_at    = cyc;
            cur_len    = 0;
            rise_cause = int'(bus.io_cause);
         end
         cur_len++;
      end else if (prev_req) begin
         pulse_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got pulse at cycle %0d len %0d expected none",
                     rise_at, cur_len);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_cause", rise_cause, mon_e.cause);
            check("pulse_len", cur_len, mon_e.len);
            if (mon_e.at >= 0) check("pulse_rise_cycle", rise_at, mon_e.at);
         end
      end
      prev_req = (bus.io_reset_req === 1'b1);
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish by 1ms");
      $fatal(1, "timeout");
   end

   typedef struct {
      bit en;
      int kick_p;       // kick every kick_p cycles, 0 = never
      int n;            // cycles driven
      int exp_pulses;
      int exp_cause;    // io_cause after the row
   } wdt_vec_t;

   wdt_vec_t vecs[6];
   int       pc0;
   int       base;

   initial begin
      vecs[0] = '{1'b0,  0, 300, 0, 0};  // disabled: never expires
      vecs[1] = '{1'b1, 40, 500, 0, 0};  // regular kicks
      vecs[2] = '{1'b1, 63, 300, 0, 0};  // kick lands when count is 1
      vecs[3] = '{1'b1,  0,  62, 0, 0};  // stopped short of expiry
      vecs[4] = '{1'b1,  0,  64, 1, 2};  // 63 decrements, expiry on 64th edge
      vecs[5] = '{1'b1, 64,  64, 1, 2};  // kick in the expiry cycle is too late

      bus.io_button_n   = 1'b1;
      bus.io_terminate  = 1'b0;
      bus.io_kick       = 1'b0;
      bus.io_wdt_enable = 1'b0;
      reset = 1'b1;
      step(3);
      reset = 1'b0;

      check("rst_reset_req", int'(bus.io_reset_req), 0);
      check("rst_halted", int'(bus.io_halted), 0);
      check("rst_cause", int'(bus.io_cause), int'(CAUSE_NONE));
      step(2);

      // watchdog table
      foreach (vecs[r]) begin
         pc0  = pulse_count;
         base = cyc;
         if (vecs[r].exp_pulses == 1) sb.push_back('{int'(CAUSE_WDT), 4, base + 64});
         for (int c = 0; c < vecs[r].n; c++) begin
            bus.io_wdt_enable = vecs[r].en;
            bus.io_kick = (vecs[r].kick_p != 0) && ((c % vecs[r].kick_p) == vecs[r].kick_p - 1);
            step(1);
         end
         bus.io_wdt_enable = 1'b0;
         bus.io_kick = 1'b0;
         step(12);
         check($sformatf("wdt_row%0d_pulses", r), pulse_count - pc0, vecs[r].exp_pulses);
         check($sformatf("wdt_row%0d_cause", r), int'(bus.io_cause), vecs[r].exp_cause);
         check($sformatf("wdt_row%0d_halted", r), int'(bus.io_halted), 0);
      end

      // plain button press
      pc0 = pulse_count;
      sb.push_back('{int'(CAUSE_BUTTON), 4, -1});
      bus.io_button_n = 1'b0;
      step(40);
      check("btn_pulses", pulse_count - pc0, 1);
      check("btn_cause", int'(bus.io_cause), int'(CAUSE_BUTTON));
      bus.io_button_n = 1'b1;
      step(30);

      // bounce: low 5 / high 1 never reaches 16 stable cycles
      pc0 = pulse_count;
      for (int k = 0; k < 20; k++) begin
         bus.io_button_n = 1'b0;
         step(5);
         bus.io_button_n = 1'b1;
         step(1);
      end
      step(30);
      check("bounce_pulses", pulse_count - pc0, 0);

      // terminate -> halted, watchdog frozen, terminate/kick ignored
      pc0 = pulse_count;
      bus.io_terminate = 1'b1;
      step(1);
      bus.io_terminate = 1'b0;
      check("term_halted_next", int'(bus.io_halted), 1);
      bus.io_wdt_enable = 1'b1;
      for (int c = 0; c < 200; c++) begin
         bus.io_terminate = (c == 50);
         bus.io_kick      = (c == 100);
         step(1);
      end
      bus.io_wdt_enable = 1'b0;
      check("halted_wdt_pulses", pulse_count - pc0, 0);
      check("halted_still", int'(bus.io_halted), 1);
      sb.push_back('{int'(CAUSE_BUTTON), 4, -1});
      bus.io_button_n = 1'b0;
      step(30);
      check("halted_btn_pulses", pulse_count - pc0, 1);
      check("halted_btn_cause", int'(bus.io_cause), int'(CAUSE_BUTTON));
      check("halted_cleared", int'(bus.io_halted), 0);
      bus.io_button_n = 1'b1;
      step(30);

      // button event and watchdog expiry in the same cycle: press drawn at
      // c=45 reaches the FSM 19 edges later (2 sync + 16 debounce + press
      // flop), i.e. on the same 64th edge the watchdog expires.
      pc0  = pulse_count;
      base = cyc;
      sb.push_back('{int'(CAUSE_BUTTON), 4, base + 64});
      for (int c = 0; c < 64; c++) begin
         bus.io_wdt_enable = 1'b1;
         bus.io_button_n   = (c >= 45) ? 1'b0 : 1'b1;
         step(1);
      end
      bus.io_wdt_enable = 1'b0;
      step(12);
      check("coinc_pulses", pulse_count - pc0, 1);
      check("coinc_cause", int'(bus.io_cause), int'(CAUSE_BUTTON));
      bus.io_button_n = 1'b1;
      step(30);

      // terminate in the expiry cycle: watchdog wins, never halted
      pc0  = pulse_count;
      base = cyc;
      sb.push_back('{int'(CAUSE_WDT), 4, base + 64});
      for (int c = 0; c < 64; c++) begin
         bus.io_wdt_enable = 1'b1;
         bus.io_terminate  = (c == 63);
         step(1);
      end
      bus.io_terminate  = 1'b0;
      bus.io_wdt_enable = 1'b0;
      check("term_exp_halted_a", int'(bus.io_halted), 0);
      step(12);
      check("term_exp_halted_b", int'(bus.io_halted), 0);
      check("term_exp_pulses", pulse_count - pc0, 1);
      check("term_exp_cause", int'(bus.io_cause), int'(CAUSE_WDT));

      // reset in the second pulse cycle aborts the pulse
      sb.push_back('{int'(CAUSE_BUTTON), 2, -1});
      bus.io_button_n = 1'b0;
      for (int i = 0; i < 40 && bus.io_reset_req !== 1'b1; i++) step(1);
      check("rstpulse_seen", int'(bus.io_reset_req), 1);
      step(1);
      check("rstpulse_2nd_cycle", int'(bus.io_reset_req), 1);
      reset = 1'b1;
      bus.io_button_n = 1'b1;
      step(1);
      check("rstpulse_req_off", int'(bus.io_reset_req), 0);
      check("rstpulse_cause_none", int'(bus.io_cause), int'(CAUSE_NONE));
      reset = 1'b0;
      step(30);

      // hold across pulse end: no repeat until release and re-press
      pc0 = pulse_count;
      sb.push_back('{int'(CAUSE_BUTTON), 4, -1});
      bus.io_button_n = 1'b0;
      step(100);
      check("hold_pulses", pulse_count - pc0, 1);
      bus.io_button_n = 1'b1;
      step(30);
      check("release_pulses", pulse_count - pc0, 1);
      sb.push_back('{int'(CAUSE_BUTTON), 4, -1});
      bus.io_button_n = 1'b0;
      step(30);
      check("repress_pulses", pulse_count - pc0, 2);
      bus.io_button_n = 1'b1;
      step(30);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
